// File: rtl/serial_resposta_pkg.sv
// Shared constants for the serial response sender: FSM state codes, message
// select values and the 4x3 ASCII message ROM.
package serial_resposta_pkg;

    localparam int BAUD_DIV_DEFAULT = 434;
    localparam int MSG_LEN          = 3;

    localparam logic [1:0] CODIGO_OK = 2'b00;
    localparam logic [1:0] CODIGO_ER = 2'b01;
    localparam logic [1:0] CODIGO_BL = 2'b10;
    localparam logic [1:0] CODIGO_GR = 2'b11;

    typedef enum logic [3:0] {
        ST_INICIAL   = 4'd0,
        ST_CARREGA   = 4'd1,
        ST_TRANSMITE = 4'd2,
        ST_PROXIMO   = 4'd3,
        ST_FINAL     = 4'd4
    } estado_t;

    // Row = codigo, column = character index.
    localparam logic [7:0] MSG_ROM [4][3] = '{
        '{8'h4F, 8'h4B, 8'h0A},   // "OK\n"
        '{8'h45, 8'h52, 8'h0A},   // "ER\n"
        '{8'h42, 8'h4C, 8'h0A},   // "BL\n"
        '{8'h47, 8'h52, 8'h0A}    // "GR\n"
    };

endpackage

// File: rtl/tx_serial_8N1.sv
// UART 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit, each
// held BAUD_DIV cycles. Line drops on the cycle after partida is sampled idle.
module tx_serial_8N1
    import serial_resposta_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic [7:0] dados,
    output logic       saida_serial,
    output logic       pronto
);

    localparam int             CW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0]  BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [3:0]     BIT_STOP  = 4'd9;

    logic          ativo;
    logic [CW-1:0] cnt_ciclo;
    logic [3:0]    cnt_bit;
    logic [7:0]    desloc;
    logic          fim_bit;

    assign fim_bit = (cnt_ciclo == BAUD_LAST);
    // High during the final cycle of the stop bit, so the caller can leave on the next edge.
    assign pronto  = ativo && (cnt_bit == BIT_STOP) && fim_bit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ativo        <= 1'b0;
            cnt_ciclo    <= '0;
            cnt_bit      <= '0;
            desloc       <= '0;
            saida_serial <= 1'b1;
        end else if (!ativo) begin
            saida_serial <= 1'b1;
            if (partida) begin
                ativo        <= 1'b1;
                cnt_ciclo    <= '0;
                cnt_bit      <= '0;
                desloc       <= dados;
                saida_serial <= 1'b0;
            end
        end else if (fim_bit) begin
            cnt_ciclo <= '0;
            if (cnt_bit == BIT_STOP) begin
                ativo <= 1'b0;
            end else begin
                // Ones shift in behind the data, so the ninth shift yields the stop bit.
                cnt_bit      <= cnt_bit + 4'd1;
                saida_serial <= desloc[0];
                desloc       <= {1'b1, desloc[7:1]};
            end
        end else begin
            cnt_ciclo <= cnt_ciclo + 1'b1;
        end
    end

endmodule

// File: rtl/serial_resposta.sv
// Message sequencer: on partida sends the 3-character ASCII reply chosen by
// codigo over a UART 8N1 line, then pulses pronto for one cycle.
module serial_resposta
    import serial_resposta_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic [1:0] codigo,
    output logic       saida_serial,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    estado_t    estado;
    logic [1:0] codigo_reg;
    logic [1:0] indice;
    logic       tx_partida;
    logic       tx_pronto;
    logic [7:0] tx_dados;

    assign tx_partida = (estado == ST_CARREGA);
    assign tx_dados   = MSG_ROM[codigo_reg][indice];
    assign db_estado  = estado;

    tx_serial_8N1 #(.BAUD_DIV(BAUD_DIV)) u_tx (
        .clock        (clock),
        .reset        (reset),
        .partida      (tx_partida),
        .dados        (tx_dados),
        .saida_serial (saida_serial),
        .pronto       (tx_pronto)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado     <= ST_INICIAL;
            codigo_reg <= '0;
            indice     <= '0;
            ocupado    <= 1'b0;
            pronto     <= 1'b0;
        end else begin
            case (estado)
                ST_INICIAL: begin
                    if (partida) begin
                        codigo_reg <= codigo;
                        indice     <= '0;
                        ocupado    <= 1'b1;
                        estado     <= ST_CARREGA;
                    end
                end
                ST_CARREGA: begin
                    estado <= ST_TRANSMITE;
                end
                ST_TRANSMITE: begin
                    if (tx_pronto) begin
                        if (indice < 2'(MSG_LEN - 1)) begin
                            estado <= ST_PROXIMO;
                        end else begin
                            pronto <= 1'b1;
                            estado <= ST_FINAL;
                        end
                    end
                end
                ST_PROXIMO: begin
                    indice <= indice + 2'd1;
                    estado <= ST_CARREGA;
                end
                ST_FINAL: begin
                    pronto  <= 1'b0;
                    ocupado <= 1'b0;
                    estado  <= ST_INICIAL;
                end
                default: begin
                    pronto  <= 1'b0;
                    ocupado <= 1'b0;
                    estado  <= ST_INICIAL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_resposta.sv
// Bench for serial_resposta at BAUD_DIV=4: table of messages, corner sequences,
// randomized traffic checked against a UART decoder and an ASCII message table.
`timescale 1ns/1ps
module tb_serial_resposta;

    localparam int BD = 4;

    logic       clock   = 1'b0;
    logic       reset   = 1'b0;
    logic       partida = 1'b0;
    logic [1:0] codigo  = 2'b00;
    logic       saida_serial, ocupado, pronto;
    logic [3:0] db_estado;

    serial_resposta #(.BAUD_DIV(BD)) dut (
        .clock        (clock),
        .reset        (reset),
        .partida      (partida),
        .codigo       (codigo),
        .saida_serial (saida_serial),
        .ocupado      (ocupado),
        .pronto       (pronto),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // UART receiver: samples mid-bit, pushes decoded bytes, counts bad stop bits.
    logic [7:0] rx_q[$];
    int         rx_rd      = 0;
    int         frame_err  = 0;
    int         pronto_cnt = 0;
    logic       mon_act    = 1'b0;
    int         mon_cnt    = 0;
    logic [7:0] mon_sh     = 8'h00;

    always @(negedge clock) begin
        if (pronto) pronto_cnt <= pronto_cnt + 1;
        if (reset) begin
            mon_act <= 1'b0;
        end else if (!mon_act) begin
            if (!saida_serial) begin
                mon_act <= 1'b1;
                mon_cnt <= 1;
            end
        end else begin
            mon_cnt <= mon_cnt + 1;
            if ((mon_cnt % BD == BD / 2) && (mon_cnt > BD) && (mon_cnt < 9 * BD))
                mon_sh <= {saida_serial, mon_sh[7:1]};
            if (mon_cnt == 9 * BD + BD / 2) begin
                if (!saida_serial) frame_err <= frame_err + 1;
                rx_q.push_back(mon_sh);
                mon_act <= 1'b0;
            end
        end
    end

    // Sample k = outputs seen at the negedge k cycles after partida is raised.
    logic       ln [0:511];
    logic       pr [0:511];
    logic       oc [0:511];
    logic [3:0] st [0:511];

    task automatic capture(input logic [1:0] cod, input int n, input bit hold,
                           input int inj_k, input logic [1:0] inj_cod);
        codigo  = cod;
        partida = 1'b1;
        ln[0] = saida_serial; pr[0] = pronto; oc[0] = ocupado; st[0] = db_estado;
        for (int k = 1; k <= n; k++) begin
            @(negedge clock);
            if (!hold) partida = (k == inj_k);
            if (k == inj_k) codigo = inj_cod;
            ln[k] = saida_serial; pr[k] = pronto; oc[k] = ocupado; st[k] = db_estado;
        end
        if (!hold) partida = 1'b0;
    endtask

    // Reference line level at sample k of a message: idle, then three 10-bit
    // frames of BD cycles each, separated by 2 extra idle cycles.
    function automatic logic exp_line(input logic [2:0][7:0] b, input int k);
        int t, c, off, bitn;
        if (k < 2) return 1'b1;
        t = k - 2;
        c = t / (10 * BD + 2);
        if (c > 2) return 1'b1;
        off  = t % (10 * BD + 2);
        bitn = off / BD;
        if (bitn == 0) return 1'b0;
        if (bitn <= 8) return b[c][bitn-1];
        return 1'b1;
    endfunction

    task automatic check_wave(input string name, input logic [2:0][7:0] b,
                              input int n, input int period);
        int bad_l = 0;
        int bad_p = 0;
        int bad_o = 0;
        for (int k = 0; k <= n; k++) begin
            int loc;
            loc = (period > 0) ? (k % period) : k;
            if (ln[k] !== exp_line(b, loc)) bad_l++;
            if (pr[k] !== (loc == 126)) bad_p++;
            if (oc[k] !== (loc >= 1 && loc <= 126)) bad_o++;
        end
        check({name, "_line_bad_cycles"}, bad_l, 0);
        check({name, "_pronto_bad_cycles"}, bad_p, 0);
        check({name, "_ocupado_bad_cycles"}, bad_o, 0);
    endtask

    task automatic check_byte(input string name, input logic [7:0] e);
        if (rx_rd < rx_q.size()) begin
            check(name, rx_q[rx_rd], e);
            rx_rd++;
        end else begin
            check({name, "_missing"}, -1, e);
        end
    endtask

    typedef struct {
        logic [1:0] cod;
        logic [7:0] b0, b1, b2;
    } vec_t;

    vec_t       tbl [4];
    string      msgs [4];
    logic [7:0] exp_q[$];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int p0, p1, s2, c, gap;
        bit seen;
        logic [2:0][7:0] bb;

        tbl[0] = '{2'b00, 8'h4F, 8'h4B, 8'h0A};
        tbl[1] = '{2'b01, 8'h45, 8'h52, 8'h0A};
        tbl[2] = '{2'b10, 8'h42, 8'h4C, 8'h0A};
        tbl[3] = '{2'b11, 8'h47, 8'h52, 8'h0A};
        msgs[0] = "OK\n"; msgs[1] = "ER\n"; msgs[2] = "BL\n"; msgs[3] = "GR\n";

        // Reset with partida high: reset must win.
        partida = 1'b1;
        #2 reset = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_line", saida_serial, 1);
        check("reset_ocupado", ocupado, 0);
        check("reset_pronto", pronto, 0);
        check("reset_db_estado", db_estado, 0);
        reset = 1'b0;
        partida = 1'b0;
        repeat (2) @(negedge clock);
        check("idle_db_estado", db_estado, 0);

        // Table: each message back-to-back.
        for (int i = 0; i < 4; i++) begin
            bb = {tbl[i].b2, tbl[i].b1, tbl[i].b0};
            capture(tbl[i].cod, 130, 1'b0, -1, 2'b00);
            check_wave($sformatf("row%0d", i), bb, 130, 0);
            check($sformatf("row%0d_db_carrega", i), st[1], 1);
            check($sformatf("row%0d_db_proximo", i), st[42], 3);
            check($sformatf("row%0d_db_final", i), st[126], 4);
            check_byte($sformatf("row%0d_byte0", i), tbl[i].b0);
            check_byte($sformatf("row%0d_byte1", i), tbl[i].b1);
            check_byte($sformatf("row%0d_byte2", i), tbl[i].b2);
        end

        // partida and codigo changed mid-message are ignored.
        bb = {tbl[0].b2, tbl[0].b1, tbl[0].b0};
        capture(2'b00, 130, 1'b0, 50, 2'b10);
        check_wave("midchange", bb, 130, 0);
        for (int j = 0; j < 3; j++) check_byte($sformatf("midchange_byte%0d", j), msgs[0][j]);

        // Reset mid-character.
        capture(2'b00, 60, 1'b0, -1, 2'b00);
        check("rst_pre_db_estado", st[60], 2);
        reset = 1'b1;
        #1;
        check("rst_line_now", saida_serial, 1);
        check("rst_db_now", db_estado, 0);
        check("rst_ocupado_now", ocupado, 0);
        partida = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_with_partida_db", db_estado, 0);
        reset = 1'b0;
        partida = 1'b0;
        p0 = pronto_cnt;
        repeat (150) @(negedge clock);
        check("rst_no_pronto", pronto_cnt - p0, 0);
        rx_rd = rx_q.size();
        capture(2'b00, 130, 1'b0, -1, 2'b00);
        check_wave("after_rst", bb, 130, 0);
        for (int j = 0; j < 3; j++) check_byte($sformatf("after_rst_byte%0d", j), msgs[0][j]);

        // partida held high: messages repeat every 127 cycles.
        bb = {tbl[3].b2, tbl[3].b1, tbl[3].b0};
        capture(2'b11, 300, 1'b1, -1, 2'b00);
        partida = 1'b0;
        check_wave("held", bb, 300, 127);
        p1 = -1;
        s2 = -1;
        for (int k = 0; k <= 300; k++) if (p1 < 0 && pr[k]) p1 = k;
        for (int k = 0; k <= 300; k++) if (p1 >= 0 && s2 < 0 && k > p1 && !ln[k]) s2 = k;
        check("held_restart_gap", s2 - p1, 3);
        repeat (200) @(negedge clock);
        for (int m = 0; m < 3; m++)
            for (int j = 0; j < 3; j++) check_byte($sformatf("held_m%0d_byte%0d", m, j), msgs[3][j]);

        // Randomized traffic with noisy codigo/partida during each message.
        for (int m = 0; m < 8; m++) begin
            c = $urandom_range(0, 3);
            for (int j = 0; j < 3; j++) exp_q.push_back(msgs[c][j]);
            codigo  = 2'(c);
            partida = 1'b1;
            @(negedge clock);
            partida = 1'b0;
            seen = 1'b0;
            for (int k = 0; k < 200 && !seen; k++) begin
                @(negedge clock);
                codigo  = 2'($urandom_range(0, 3));
                partida = (k < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
                if (pronto) seen = 1'b1;
            end
            partida = 1'b0;
            check($sformatf("rnd%0d_pronto_seen", m), seen, 1);
            gap = $urandom_range(0, 15);
            repeat (gap) @(negedge clock);
        end
        repeat (5) @(negedge clock);
        for (int i = 0; i < exp_q.size(); i++) check_byte($sformatf("rnd_byte%0d", i), exp_q[i]);

        check("rx_extra_bytes", rx_q.size() - rx_rd, 0);
        check("frame_errors", frame_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
